// File: rtl/pmp_pkg.sv
// Shared PMP region programmer types and CSR constants.
// TOR support throughout the block is enabled by defining PMP_TOR_EN.
package pmp_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        TOR   = 2'd1,
        NA4   = 2'd2,
        NAPOT = 2'd3
    } pmp_a_e;

    typedef enum logic [1:0] {
        OK     = 2'd0,
        ALIGN  = 2'd1,
        LOCKED = 2'd2,
        RANGE  = 2'd3
    } pmp_err_e;

    localparam logic [11:0] PMPCFG_BASE  = 12'h3A0;
    localparam logic [11:0] PMPADDR_BASE = 12'h3B0;

    localparam int CFG_R    = 0;
    localparam int CFG_W    = 1;
    localparam int CFG_X    = 2;
    localparam int CFG_A_LO = 3;
    localparam int CFG_A_HI = 4;
    localparam int CFG_L    = 7;

    function automatic logic [7:0] cfg_byte(
        input logic       l,
        input pmp_a_e     a,
        input logic [2:0] perm
    );
        logic [7:0] b;
        b                   = '0;
        b[CFG_R]            = perm[0];
        b[CFG_W]            = perm[1];
        b[CFG_X]            = perm[2];
        b[CFG_A_HI:CFG_A_LO] = a;
        b[CFG_L]            = l;
        return b;
    endfunction

endpackage

// File: rtl/pmp_region_encode.sv
// Combinational region classifier, error checker and pmpaddr encoder.
// TOR classification exists only when PMP_TOR_EN is defined.
module pmp_region_encode
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    localparam int EW = $clog2(NUM_ENTRIES)
) (
    input  logic [EW-1:0] i_entry,
    input  logic [31:0]   i_base,
    input  logic [31:0]   i_size,
    input  logic          i_cur_lock,
    input  logic          i_prev_lock,
    input  pmp_a_e        i_prev_a,
    output pmp_a_e        o_mode,
    output pmp_err_e      o_err,
    output logic [31:0]   o_prev_addr,
    output logic [31:0]   o_addr
);

`ifdef PMP_TOR_EN
    localparam bit TOR_EN = 1'b1;
`else
    localparam bit TOR_EN = 1'b0;
`endif

    logic        w_na4;
    logic        w_pow2;
    logic        w_napot;
    logic        w_tor;
    logic        w_first;
    logic        w_ovf;
    logic [32:0] w_sum;
    logic [31:0] w_mask;

    assign w_mask  = i_size - 32'd1;
    assign w_na4   = (i_size == 32'd4) && (i_base[1:0] == 2'b00);
    assign w_pow2  = (i_size != '0) && ((i_size & w_mask) == '0);
    assign w_napot = w_pow2 && (i_size >= 32'd8)
                     && ((i_base & w_mask) == '0);
    assign w_tor   = TOR_EN && (i_size != '0)
                     && (i_base[1:0] == 2'b00)
                     && (i_size[1:0] == 2'b00)
                     && !w_na4 && !w_napot;

    // Region may end exactly at 2^32 but not beyond it.
    assign w_sum   = {1'b0, i_base} + {1'b0, i_size};
    assign w_ovf   = w_sum > 33'h1_0000_0000;
    assign w_first = (i_entry == '0);

    always_comb begin
        o_mode = OFF;
        if (w_na4) begin
            o_mode = NA4;
        end else if (w_napot) begin
            o_mode = NAPOT;
        end else if (w_tor) begin
            o_mode = TOR;
        end
    end

    always_comb begin
        o_err = OK;
        if (i_cur_lock || (w_tor && !w_first && i_prev_lock)) begin
            o_err = LOCKED;
        end else if ((i_size == '0) || !(w_na4 || w_napot || w_tor)) begin
            o_err = ALIGN;
        end else if (w_tor && (w_first || w_ovf || (i_prev_a != OFF))) begin
            o_err = RANGE;
        end
    end

    assign o_prev_addr = {2'b00, i_base[31:2]};

    always_comb begin
        o_addr = '0;
        unique case (o_mode)
            NA4:     o_addr = {2'b00, i_base[31:2]};
            NAPOT:   o_addr = {2'b00, i_base[31:2]} | ((i_size >> 3) - 32'd1);
            TOR:     o_addr = {1'b0, w_sum[32:2]};
            default: o_addr = '0;
        endcase
    end

endmodule

// File: rtl/pmp_region_programmer.sv
// Programs one PMP entry through CSR writes and keeps a cfg shadow.
// Define PMP_TOR_EN to enable TOR regions and the WR_BASE state.
module pmp_region_programmer
    import pmp_pkg::*;
#(
    parameter int NUM_ENTRIES = 16,
    localparam int EW = $clog2(NUM_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [EW-1:0] req_entry,
    input  logic [31:0]   req_base,
    input  logic [31:0]   req_size,
    input  logic [2:0]    req_perm,
    input  logic          req_lock,
    output logic          rsp_valid,
    output logic [1:0]    rsp_err,
    output logic          csr_we,
    output logic [11:0]   csr_addr,
    output logic [31:0]   csr_wdata,
    input  logic          csr_ack
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        WR_BASE,
        WR_ADDR,
        WR_CFG,
        RESP
    } state_e;

    state_e      r_state;
    state_e      w_next;

    logic [EW-1:0] r_entry;
    logic [31:0]   r_base;
    logic [31:0]   r_size;
    logic [2:0]    r_perm;
    logic          r_lock;
    pmp_a_e        r_mode;
    pmp_err_e      r_err;
    logic [7:0]    r_shadow [NUM_ENTRIES];

    logic [EW-1:0] w_prev;
    pmp_a_e        w_mode;
    pmp_err_e      w_err;
    logic [31:0]   w_prev_addr;
    logic [31:0]   w_addr;
    logic [7:0]    w_new_byte;
    logic [31:0]   w_cfg_word;
    logic          w_accept;

    assign req_ready = rst_n && (r_state == IDLE);
    assign w_accept  = req_valid && req_ready;
    assign w_prev    = r_entry - EW'(1);

    pmp_region_encode #(
        .NUM_ENTRIES (NUM_ENTRIES)
    ) u_encode (
        .i_entry     (r_entry),
        .i_base      (r_base),
        .i_size      (r_size),
        .i_cur_lock  (r_shadow[r_entry][CFG_L]),
        .i_prev_lock (r_shadow[w_prev][CFG_L]),
        .i_prev_a    (pmp_a_e'(r_shadow[w_prev][CFG_A_HI:CFG_A_LO])),
        .o_mode      (w_mode),
        .o_err       (w_err),
        .o_prev_addr (w_prev_addr),
        .o_addr      (w_addr)
    );

    assign w_new_byte = cfg_byte(r_lock, r_mode, r_perm);

    // Merge the new byte into the other three shadow bytes of its word.
    always_comb begin
        w_cfg_word = '0;
        for (int b = 0; b < 4; b++) begin
            if (2'(b) == r_entry[1:0]) begin
                w_cfg_word[8*b +: 8] = w_new_byte;
            end else begin
                w_cfg_word[8*b +: 8] = r_shadow[{r_entry[EW-1:2], 2'(b)}];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_entry <= '0;
            r_base  <= '0;
            r_size  <= '0;
            r_perm  <= '0;
            r_lock  <= 1'b0;
            r_mode  <= OFF;
            r_err   <= OK;
            for (int k = 0; k < NUM_ENTRIES; k++) begin
                r_shadow[k] <= '0;
            end
        end else begin
            r_state <= w_next;
            if (w_accept) begin
                r_entry <= req_entry;
                r_base  <= req_base;
                r_size  <= req_size;
                r_perm  <= req_perm;
                r_lock  <= req_lock;
            end
            // Verdict is frozen here; the shadow may change before RESP.
            if (r_state == CHECK) begin
                r_mode <= w_mode;
                r_err  <= w_err;
            end
            if ((r_state == WR_CFG) && csr_ack) begin
                r_shadow[r_entry] <= w_new_byte;
            end
        end
    end

    always_comb begin
        w_next    = r_state;
        csr_we    = 1'b0;
        csr_addr  = '0;
        csr_wdata = '0;
        rsp_valid = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = CHECK;
                end
            end
            CHECK: begin
                if (w_err != OK) begin
                    w_next = RESP;
                end else begin
                    w_next = WR_ADDR;
`ifdef PMP_TOR_EN
                    if (w_mode == TOR) begin
                        w_next = WR_BASE;
                    end
`endif
                end
            end
            WR_BASE: begin
                csr_we    = 1'b1;
                csr_addr  = PMPADDR_BASE + 12'(w_prev);
                csr_wdata = w_prev_addr;
                if (csr_ack) begin
                    w_next = WR_ADDR;
                end
            end
            WR_ADDR: begin
                csr_we    = 1'b1;
                csr_addr  = PMPADDR_BASE + 12'(r_entry);
                csr_wdata = w_addr;
                if (csr_ack) begin
                    w_next = WR_CFG;
                end
            end
            WR_CFG: begin
                csr_we    = 1'b1;
                csr_addr  = PMPCFG_BASE + 12'(r_entry >> 2);
                csr_wdata = w_cfg_word;
                if (csr_ack) begin
                    w_next = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                w_next    = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    assign rsp_err = (r_state == RESP) ? r_err : OK;

endmodule

// File: tb/tb_pmp_region_programmer.sv
// Randomised and directed bench for pmp_region_programmer.
// Model follows PMP_TOR_EN when the macro is defined for the build.
module tb_pmp_region_programmer;

    localparam int N = 16;

`ifdef PMP_TOR_EN
    localparam bit TOR_EN = 1'b1;
`else
    localparam bit TOR_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_entry;
    logic [31:0] req_base;
    logic [31:0] req_size;
    logic [2:0]  req_perm;
    logic        req_lock;
    logic        rsp_valid;
    logic [1:0]  rsp_err;
    logic        csr_we;
    logic [11:0] csr_addr;
    logic [31:0] csr_wdata;
    logic        csr_ack;

    pmp_region_programmer #(
        .NUM_ENTRIES (N)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_entry (req_entry),
        .req_base  (req_base),
        .req_size  (req_size),
        .req_perm  (req_perm),
        .req_lock  (req_lock),
        .rsp_valid (rsp_valid),
        .rsp_err   (rsp_err),
        .csr_we    (csr_we),
        .csr_addr  (csr_addr),
        .csr_wdata (csr_wdata),
        .csr_ack   (csr_ack)
    );

    typedef struct {
        logic [11:0] a;
        logic [31:0] d;
    } wr_t;

    int   checks = 0;
    int   errors = 0;
    int   mdl_sh [N];
    wr_t  exp_q [$];
    int   exp_err;
    bit   pending;
    int   ack_mode;

    int   pred_err;
    int   pred_n;
    int   pred_byte;
    wr_t  pred_w [3];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected outcome of one request from the architectural PMP rules.
    task automatic predict(input int e, input logic [31:0] b,
                           input logic [31:0] s, input logic [2:0] p,
                           input logic l);
        bit     na4;
        bit     napot;
        bit     tor;
        bit     locked;
        longint top;
        int     prev_a;
        int     a_new;
        longint word;
        na4    = (s == 4) && (b % 4 == 0);
        napot  = ($countones(s) == 1) && (s >= 8) && (b % s == 0);
        tor    = TOR_EN && (s != 0) && (b % 4 == 0) && (s % 4 == 0)
                 && !na4 && !napot;
        top    = longint'(b) + longint'(s);
        locked = (mdl_sh[e] >= 128) || (tor && e > 0 && mdl_sh[e-1] >= 128);
        prev_a = (e > 0) ? (mdl_sh[e-1] / 8) % 4 : 0;
        pred_n = 0;
        if (locked) pred_err = 2;
        else if (s == 0 || !(na4 || napot || tor)) pred_err = 1;
        else if (tor && (e == 0 || top > 64'h1_0000_0000 || prev_a != 0))
            pred_err = 3;
        else pred_err = 0;
        pred_byte = 0;
        if (pred_err == 0) begin
            a_new = na4 ? 2 : (napot ? 3 : 1);
            if (tor) begin
                pred_w[0] = '{12'(32'h3B0 + e - 1), 32'(b / 4)};
                pred_w[1] = '{12'(32'h3B0 + e), 32'(top / 4)};
                pred_n = 2;
            end else begin
                pred_w[0] = '{12'(32'h3B0 + e),
                              napot ? 32'(b / 4 + s / 8 - 1) : 32'(b / 4)};
                pred_n = 1;
            end
            pred_byte = int'(l) * 128 + a_new * 8 + int'(p);
            word = 0;
            for (int k = 0; k < 4; k++) begin
                if (k == e % 4) word += longint'(pred_byte) << (8 * k);
                else word += longint'(mdl_sh[(e / 4) * 4 + k]) << (8 * k);
            end
            pred_w[pred_n] = '{12'(32'h3A0 + e / 4), 32'(word)};
            pred_n++;
        end
    endtask

    task automatic arm();
        exp_err = pred_err;
        for (int i = 0; i < pred_n; i++) exp_q.push_back(pred_w[i]);
        pending = 1'b1;
    endtask

    task automatic do_req(input int e, input logic [31:0] b,
                          input logic [31:0] s, input logic [2:0] p,
                          input logic l, input bit chk_lat);
        int cyc;
        bit got;
        predict(e, b, s, p, l);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!req_ready && cyc < 50);
        check("ready_before_req", req_ready, 1);
        arm();
        req_valid = 1'b1;
        req_entry = 4'(e);
        req_base  = b;
        req_size  = s;
        req_perm  = p;
        req_lock  = l;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_entry = 4'($urandom);
        req_base  = $urandom;
        req_size  = $urandom;
        req_perm  = 3'($urandom);
        req_lock  = 1'($urandom);
        got = 1'b0;
        cyc = 0;
        while (!got && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid) got = 1'b1;
        end
        check("rsp_seen", got, 1);
        if (got && chk_lat) check("latency", cyc, 2 + pred_n);
        if (got && pred_err == 0) mdl_sh[e] = pred_byte;
    endtask

    task automatic clear_model();
        exp_q.delete();
        pending = 1'b0;
        for (int i = 0; i < N; i++) mdl_sh[i] = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        clear_model();
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (ack_mode)
                0:       csr_ack = 1'($urandom % 3 != 0);
                1:       csr_ack = 1'b1;
                default: csr_ack = 1'b0;
            endcase
        end
    end

    // Single compare process: CSR writes and responses against the model.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (exp_q.size() == 0) begin
                    check("no_we", csr_we, 0);
                end else if (csr_we) begin
                    check("csr_addr", csr_addr, exp_q[0].a);
                    check("csr_wdata", csr_wdata, exp_q[0].d);
                    if (csr_ack) void'(exp_q.pop_front());
                end
                if (rsp_valid) begin
                    check("rsp_pending", rsp_valid, pending);
                    if (pending) begin
                        check("rsp_err", rsp_err, exp_err);
                        check("writes_left", exp_q.size(), 0);
                    end
                    pending = 1'b0;
                end
            end
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int    e;
        int    cat;
        int    k;
        logic [31:0] b;
        logic [31:0] s;
        int    cyc;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_entry = '0;
        req_base  = '0;
        req_size  = '0;
        req_perm  = '0;
        req_lock  = 1'b0;
        csr_ack   = 1'b1;
        ack_mode  = 1;
        clear_model();

        repeat (3) @(negedge clk);
        check("rst_ready", req_ready, 0);
        check("rst_we", csr_we, 0);
        check("rst_addr", csr_addr, 0);
        check("rst_wdata", csr_wdata, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_err", rsp_err, 0);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", req_ready, 1);

        predict(2, 32'h100, 32'h4, 3'b011, 1'b0);
        check("pin_na4_err", pred_err, 0);
        check("pin_na4_n", pred_n, 2);
        check("pin_na4_a0", pred_w[0].a, 12'h3B2);
        check("pin_na4_d0", pred_w[0].d, 32'h40);
        check("pin_na4_a1", pred_w[1].a, 12'h3A0);
        check("pin_na4_d1", pred_w[1].d, 32'h0013_0000);
        do_req(2, 32'h100, 32'h4, 3'b011, 1'b0, 1'b1);

        do_reset();
        predict(0, 32'h8000_0000, 32'h1000, 3'b111, 1'b0);
        check("pin_napot_d0", pred_w[0].d, 32'h2000_01FF);
        check("pin_napot_a1", pred_w[1].a, 12'h3A0);
        check("pin_napot_d1", pred_w[1].d, 32'h0000_001F);
        do_req(0, 32'h8000_0000, 32'h1000, 3'b111, 1'b0, 1'b1);

        do_reset();
        predict(5, 32'h1000, 32'h300, 3'b001, 1'b0);
`ifdef PMP_TOR_EN
        check("pin_tor_n", pred_n, 3);
        check("pin_tor_a0", pred_w[0].a, 12'h3B4);
        check("pin_tor_d0", pred_w[0].d, 32'h400);
        check("pin_tor_d1", pred_w[1].d, 32'h4C0);
        check("pin_tor_a2", pred_w[2].a, 12'h3A1);
        check("pin_tor_d2", pred_w[2].d, 32'h900);
`else
        check("pin_tor_align", pred_err, 1);
        check("pin_tor_n", pred_n, 0);
`endif
        do_req(5, 32'h1000, 32'h300, 3'b001, 1'b0, 1'b1);

        do_req(3, 32'h200, 32'h4, 3'b001, 1'b1, 1'b1);
        predict(3, 32'h300, 32'h4, 3'b111, 1'b0);
        check("pin_locked", pred_err, 2);
        do_req(3, 32'h300, 32'h4, 3'b111, 1'b0, 1'b1);

`ifndef PMP_TOR_EN
        predict(6, 32'h104, 32'h10, 3'b001, 1'b0);
        check("pin_align_104", pred_err, 1);
        do_req(6, 32'h104, 32'h10, 3'b001, 1'b0, 1'b1);
`endif
        predict(7, 32'h102, 32'h10, 3'b001, 1'b0);
        check("pin_align_102", pred_err, 1);
        do_req(7, 32'h102, 32'h10, 3'b001, 1'b0, 1'b1);
        predict(0, 32'h1000, 32'h300, 3'b001, 1'b0);
        check("pin_tor_e0", pred_err, TOR_EN ? 3 : 1);
        do_req(0, 32'h1000, 32'h300, 3'b001, 1'b0, 1'b1);
        predict(9, 32'hFFFF_FF00, 32'h200, 3'b001, 1'b0);
        check("pin_ovf", pred_err, TOR_EN ? 3 : 1);
        do_req(9, 32'hFFFF_FF00, 32'h200, 3'b001, 1'b0, 1'b1);

        do_reset();
        do_req(0, 32'h40, 32'h4, 3'b111, 1'b0, 1'b1);
        ack_mode = 2;
        predict(1, 32'h80, 32'h4, 3'b001, 1'b0);
        @(negedge clk);
        arm();
        req_valid = 1'b1;
        req_entry = 4'd1;
        req_base  = 32'h80;
        req_size  = 32'h4;
        req_perm  = 3'b001;
        req_lock  = 1'b0;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!csr_we && cyc < 20);
        check("stall_we", csr_we, 1);
        check("stall_addr", csr_addr, 12'h3B1);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_we", csr_we, 0);
        check("abort_addr", csr_addr, 0);
        check("abort_wdata", csr_wdata, 0);
        check("abort_ready", req_ready, 0);
        check("abort_rsp", rsp_valid, 0);
        clear_model();
        ack_mode = 1;
        repeat (2) @(negedge clk);
        #2;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_ready_after", req_ready, 1);
        check("abort_no_retry", csr_we, 0);
        predict(1, 32'h80, 32'h4, 3'b001, 1'b0);
        check("pin_cleared_word", pred_w[1].d, 32'h0000_1100);
        do_req(1, 32'h80, 32'h4, 3'b001, 1'b0, 1'b1);

        for (int it = 0; it < 300; it++) begin
            if (it % 50 == 49) do_reset();
            ack_mode = ($urandom % 2 == 0) ? 1 : 0;
            e   = int'($urandom_range(0, N - 1));
            cat = int'($urandom % 6);
            case (cat)
                0: begin
                    s = 32'h4;
                    b = $urandom & ~32'h3;
                end
                1: begin
                    k = int'($urandom_range(3, 24));
                    s = 32'h1 << k;
                    b = $urandom & ~(s - 32'h1);
                end
                2: begin
                    b = 32'($urandom_range(0, 32'h3FFF)) << 2;
                    s = 32'($urandom_range(1, 32'h400)) << 2;
                end
                3: begin
                    b = $urandom;
                    s = 32'($urandom_range(1, 64));
                end
                4: begin
                    b = $urandom | 32'h1;
                    s = ($urandom % 2 == 0) ? 32'h0 : 32'h4;
                end
                default: begin
                    b = 32'hFFFF_0000 | ($urandom & 32'hFFFC);
                    s = 32'($urandom_range(1, 32'h8000)) << 2;
                end
            endcase
            do_req(e, b, s, 3'($urandom), 1'($urandom % 8 == 0),
                   ack_mode == 1);
        end

        ack_mode = 1;
        repeat (4) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pmp_region_programmer.md
PMP_REGION_PROGRAMMER -- requirements
Module: pmp_region_programmer

Interface
REQ-001 The block SHALL have parameter NUM_ENTRIES, default 16: number of PMP entries, a power of two from 4 to 64; EW = $clog2(NUM_ENTRIES).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-003 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 The block SHALL have ports req_valid (input, 1) and req_ready (output, 1): the request handshake.
REQ-005 The block SHALL have port req_entry, input, EW bits: the target entry index i.
REQ-006 The block SHALL have ports req_base (input, 32) and req_size (input, 32): region byte base and byte size.
REQ-007 The block SHALL have ports req_perm (input, 3, {X,W,R}) and req_lock (input, 1): permissions and lock request.
REQ-008 The block SHALL have ports rsp_valid (output, 1) and rsp_err (output, 2): the completion pulse and its status.
REQ-009 The block SHALL have CSR write ports csr_we (output, 1), csr_addr (output, 12), csr_wdata (output, 32) and csr_ack (input, 1).

Function
REQ-010 A request SHALL be accepted on a clock edge where req_valid and req_ready are both high; req_ready SHALL be high only in IDLE.
REQ-011 The FSM SHALL have the states IDLE, CHECK, WR_BASE, WR_ADDR, WR_CFG and RESP.
REQ-012 The FSM SHALL follow the transitions IDLE->CHECK on accept; CHECK->RESP on error, else ->WR_BASE if the mode is TOR, else ->WR_ADDR; WR_BASE->WR_ADDR->WR_CFG->RESP; RESP->IDLE.
REQ-013 Each WR state SHALL hold csr_we, csr_addr and csr_wdata stable until a cycle with csr_ack high, then advance; csr_ack in the same cycle as csr_we SHALL be legal.
REQ-014 CHECK SHALL classify the request as NA4 when size==4 and base[1:0]==0: pmpaddr = base>>2, A=2.
REQ-015 CHECK SHALL classify the request as NAPOT when size is a power of two, size>=8 and base is aligned to size: pmpaddr = (base>>2) | ((size>>3)-1), A=3.
REQ-016 CHECK SHALL classify the request as TOR (PMP_TOR_EN only) when base and size are both 4-aligned but the request is neither NA4 nor NAPOT: WR_BASE writes pmpaddr[i-1]=base>>2, WR_ADDR writes pmpaddr[i]=(base+size)>>2, A=1.
REQ-017 Error priority SHALL be, highest first: LOCKED(2) if shadow L of entry i is set, or of entry i-1 for TOR.
REQ-018 Next in priority SHALL be ALIGN(1): size==0, or an unclassifiable request.
REQ-019 Last in priority SHALL be RANGE(3), TOR only: i==0, or the 33-bit base+size exceeds 2^32, or shadow A of entry i-1 is not OFF; otherwise rsp_err SHALL be OK(0).
REQ-020 pmpaddr writes SHALL use csr_addr = 12'h3B0+index.
REQ-021 The cfg write SHALL use csr_addr = 12'h3A0+(i>>2); csr_wdata SHALL be the shadow cfg word with byte i%4 replaced by {req_lock,2'b00,A,req_perm}.
REQ-022 The block SHALL keep a shadow of all NUM_ENTRIES cfg bytes, updated only on csr_ack of a WR_CFG write.
REQ-023 rsp_valid SHALL be a one-cycle pulse in RESP with no backpressure; rsp_err SHALL be valid only while rsp_valid is high.
REQ-024 With csr_ack tied high, rsp_valid SHALL rise 2 cycles after accept on error, 4 cycles for NA4/NAPOT and 5 cycles for TOR.
REQ-025 Request fields SHALL be registered at accept; input changes after accept SHALL have no effect.
REQ-026 An error SHALL produce no csr_we pulse.

Reset
REQ-027 rst_n low SHALL immediately force: state IDLE, csr_we=0, csr_addr=0, csr_wdata=0, rsp_valid=0, rsp_err=0 and all shadow bytes=0.
REQ-028 req_ready SHALL be 0 while rst_n is low and 1 in the first cycle after release; a write aborted by reset SHALL NOT be retried.

Configuration
REQ-029 With PMP_TOR_EN defined, TOR classification and the WR_BASE state SHALL be present.
REQ-030 Without PMP_TOR_EN, requests that are neither NA4 nor NAPOT SHALL return ALIGN, WR_BASE SHALL be unreachable, and RANGE SHALL never be reported.

Structure
REQ-031 Package pmp_pkg SHALL hold: enum pmp_a_e {OFF,TOR,NA4,NAPOT}; enum pmp_err_e {OK,ALIGN,LOCKED,RANGE}; constants PMPCFG_BASE=12'h3A0 and PMPADDR_BASE=12'h3B0; cfg bit positions R=0, W=1, X=2, A=4:3, L=7.
REQ-032 Combinational sub-module pmp_region_encode SHALL perform the classification, alignment/overflow checks and pmpaddr computation; the FSM and shadow SHALL stay in the top module.

Verification
REQ-033 Entry 2, base 0x100, size 4, perm 3'b011 -> writes (0x3B2,0x00000040) then (0x3A0,0x00130000); rsp_err=OK.
REQ-034 Entry 0, base 0x80000000, size 0x1000, perm 3'b111 -> writes (0x3B0,0x200001FF) then (0x3A0,0x0000001F); rsp_err=OK.
REQ-035 PMP_TOR_EN, entry 5, base 0x1000, size 0x300, perm 3'b001 -> writes (0x3B4,0x400), (0x3B5,0x4C0), (0x3A1,0x00000900); without the macro -> ALIGN with no writes.
REQ-036 Entry 3 programmed NA4 with req_lock=1, then entry 3 reprogrammed -> rsp_err=LOCKED with no csr_we.
REQ-037 Error cases SHALL each give 2-cycle latency with no writes: base 0x104, size 0x10 -> ALIGN; TOR at entry 0 -> RANGE; base 0xFFFFFF00, size 0x200 -> RANGE.
REQ-038 csr_ack held low in WR_ADDR, then rst_n pulsed low -> csr_we=0 immediately, shadow cleared, req_ready=1 after release.
